// File: rtl/fetch_mem_arbiter.sv
// Arbiter sharing one single-port fixed-latency SRAM between instruction fetch and the MEM
// stage. MEM has fixed priority; a taken branch discards an in-flight fetch. Also produces the
// freeze signals for the IF stage register and the downstream pipeline registers.
module fetch_mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 4,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  input  logic              i_flush,
  input  logic              i_mem_rd,
  input  logic              i_mem_wr,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata,
  output logic              o_ram_en,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic              o_if_ready,
  output logic [DATA_W-1:0] o_mem_rdata,
  output logic              o_mem_ready,
  output logic              o_if_freeze,
  output logic              o_pipe_freeze
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;
  typedef enum logic {OwnIf, OwnMem} owner_e;

  // Counter runs WAIT_CYCLES-1 down to 0, giving WAIT_CYCLES access cycles.
  localparam logic [3:0] CntLoad = 4'(WAIT_CYCLES - 1);

  state_e            r_state;
  owner_e            r_owner;
  logic [3:0]        r_cnt;
  logic              r_discard;
  logic              r_ram_en;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_mem_rdata;
  logic              r_if_done;
  logic              r_mem_ready;

  logic w_mem_req;
  logic w_if_ready;
  logic w_pipe_freeze;

  assign w_mem_req = i_mem_rd | i_mem_wr;

  // Sequencer: grant, hold the SRAM access for WAIT_CYCLES, then one completion cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_owner     <= OwnIf;
      r_cnt       <= 4'd0;
      r_discard   <= 1'b0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
      r_if_done   <= 1'b0;
      r_mem_ready <= 1'b0;
    end else begin
      r_if_done   <= 1'b0;
      r_mem_ready <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_discard <= 1'b0;
          if (w_mem_req) begin
            r_owner     <= OwnMem;
            r_ram_addr  <= i_mem_addr;
            r_ram_wdata <= i_mem_wdata;
            r_ram_we    <= i_mem_wr;
            r_ram_en    <= 1'b1;
            r_cnt       <= CntLoad;
            r_state     <= StBusy;
          end else if (i_if_req && !i_flush) begin
            r_owner    <= OwnIf;
            r_ram_addr <= i_if_addr;
            r_ram_we   <= 1'b0;
            r_ram_en   <= 1'b1;
            r_cnt      <= CntLoad;
            r_state    <= StBusy;
          end
        end
        StBusy: begin
          // A branch taken during a fetch poisons it; the access itself still completes.
          if (i_flush && r_owner == OwnIf) begin
            r_discard <= 1'b1;
          end
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            if (r_owner == OwnMem) begin
              if (!r_ram_we) begin
                r_mem_rdata <= i_ram_rdata;
              end
              r_mem_ready <= 1'b1;
            end else begin
              r_if_rdata <= i_ram_rdata;
              r_if_done  <= 1'b1;
            end
            r_ram_en <= 1'b0;
            r_ram_we <= 1'b0;
            r_state  <= StDone;
          end
        end
        StDone: begin
          r_discard <= 1'b0;
          r_state   <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // A flush in the completion cycle also suppresses the fetch result.
  assign w_if_ready    = r_if_done & ~r_discard & ~i_flush;
  assign w_pipe_freeze = w_mem_req & ~r_mem_ready;

  assign o_ram_en      = r_ram_en;
  assign o_ram_we      = r_ram_we;
  assign o_ram_addr    = r_ram_addr;
  assign o_ram_wdata   = r_ram_wdata;
  assign o_if_rdata    = r_if_rdata;
  assign o_if_ready    = w_if_ready;
  assign o_mem_rdata   = r_mem_rdata;
  assign o_mem_ready   = r_mem_ready;
  assign o_pipe_freeze = w_pipe_freeze;
  assign o_if_freeze   = w_pipe_freeze | ~w_if_ready;

endmodule
